// File: rtl/mem_ctrl_if.sv
// CPU request bus plus SRAM port of the memory controller, bundled as one interface.
// The bidirectional CPU data bus stays a plain port on the controller.
interface mem_ctrl_if #(
    parameter int ADDR_BITS = 12
);
    logic                 mem_re;
    logic                 mem_we;
    logic [29:0]          memaddr;
    logic                 mem_ready;
    logic                 bus_err;
    logic                 sram_cs;
    logic                 sram_we;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [31:0]          sram_wdata;
    logic [31:0]          sram_rdata;

    // Environment side: CPU requester and SRAM device.
    modport master (
        output mem_re, mem_we, memaddr, sram_rdata,
        input  mem_ready, bus_err, sram_cs, sram_we, sram_addr, sram_wdata
    );

    // Controller side.
    modport slave (
        input  mem_re, mem_we, memaddr, sram_rdata,
        output mem_ready, bus_err, sram_cs, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port SRAM controller: one CPU transaction at a time through
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, or IDLE -> DONE on a bad request.
module mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 12
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   bus,
    inout  wire  [31:0] memdata
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 sram_cs_q, sram_cs_d;
    logic                 sram_we_q, sram_we_d;
    logic                 ready_q, ready_d;
    logic                 bus_err_q, bus_err_d;
    logic                 addr_ok;
    logic                 md_oe;

    // Upper address bits beyond the SRAM depth must be zero for a legal access.
    assign addr_ok = (bus.memaddr[29:ADDR_BITS] == '0);

    // Next-state logic; the strobes are derived from the next state so they come out of flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_re && bus.mem_we) begin
                    // Conflicting request: fail without touching the SRAM.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    rdata_d = 32'h0;
                end else if (bus.mem_re || bus.mem_we) begin
                    rd_d = bus.mem_re;
                    if (addr_ok) begin
                        state_d = S_ACCESS;
                        cnt_d   = 4'(WAIT_CYCLES);
                        err_d   = 1'b0;
                        wr_d    = bus.mem_we;
                        addr_d  = bus.memaddr[ADDR_BITS-1:0];
                        if (bus.mem_we) begin
                            wdata_d = memdata;
                        end
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        wr_d    = 1'b0;
                        rdata_d = 32'h0;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (rd_q) begin
                        rdata_d = bus.sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        sram_cs_d = (state_d == S_ACCESS);
        sram_we_d = (state_d == S_ACCESS) && (cnt_d == 4'd0) && wr_d;
        ready_d   = (state_d == S_DONE);
        bus_err_d = (state_d == S_DONE) && err_d;
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            sram_cs_q <= 1'b0;
            sram_we_q <= 1'b0;
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            sram_cs_q <= sram_cs_d;
            sram_we_q <= sram_we_d;
            ready_q   <= ready_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.sram_cs    = sram_cs_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.mem_ready  = ready_q;
    assign bus.bus_err    = bus_err_q;

    // Read data goes onto the CPU bus only while the CPU still asks for it in DONE.
    assign md_oe   = (state_q == S_DONE) && rd_q && bus.mem_re;
    assign memdata = md_oe ? rdata_q : 32'hzzzz_zzzz;
endmodule
